directory_ctrl: RTL and testbench
=================================

DIRECTORY_CTRL -- requirements
Module: directory_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the address width.
REQ-003 Parameter DATA_W SHALL default to 8 and set the data width; the directory SHALL hold 2**ADDR_W entries.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  2  per-L1 request valid; index p is L1 port p.
REQ-007 req_ready  out  2  one-cycle grant/accept pulse to port p.
REQ-008 req_op  in  4  per-port op at [2p+1:2p]: RD_MISS=0, WR_MISS=1, WRITEBACK=2; 3 is reserved.
REQ-009 req_addr  in  2*ADDR_W  per-port address; req_data  in  2*DATA_W  per-port writeback data.
REQ-010 rsp_valid  out  2  one-cycle completion pulse to port p; rsp_data  out  DATA_W  fill data, meaningful only with rsp_valid.
REQ-011 inv_valid  out  2  invalidate to port q, held until acknowledged; inv_addr  out  ADDR_W  block address.
REQ-012 inv_ack  in  2  invalidate acknowledge pulse; inv_data  in  2*DATA_W  dirty data returned with the ack.
REQ-013 l2_valid  out  1; l2_write  out  1; l2_addr  out  ADDR_W; l2_data  out  DATA_W: request to cacheL2, held until l2_ready.
REQ-014 l2_ready  in  1; l2_rsp_valid  in  1; l2_rsp_data  in  DATA_W: L2 accept and read return.

Function
REQ-015 Each entry SHALL be {state: UNCACHED=0, SHARED=1, MODIFIED=2; sharers[1:0]}.
REQ-016 FSM states SHALL be IDLE, LOOKUP, INVAL, L2_REQ, L2_WAIT, RESP.
REQ-017 IDLE: when any req_valid is high, pulse req_ready for the winner, latch port, op, addr and data, then go to LOOKUP.
REQ-018 Simultaneous requests SHALL be granted round-robin; the pointer SHALL start at port 0 and move to the other port after each grant.
REQ-019 RD_MISS from p, line MODIFIED by q: go to INVAL(q); after inv_ack, issue an L2 write of inv_data[q]; then RESP with that data; final entry = SHARED, sharers = {p}.
REQ-020 RD_MISS from p, line UNCACHED or SHARED: L2 read; RESP with l2_rsp_data; final entry = SHARED, sharers |= p.
REQ-021 WR_MISS from p with q in sharers: go to INVAL(q) first.
REQ-022 WR_MISS: if q was MODIFIED, RESP with inv_data[q] and no L2 access; otherwise L2 read, then RESP; final entry = MODIFIED, sharers = {p}.
REQ-023 WRITEBACK from p, line MODIFIED by p: L2 write of the latched data, RESP, final entry UNCACHED with sharers 0; otherwise no L2 access and RESP only.
REQ-024 INVAL SHALL hold inv_valid[q] and inv_addr until inv_ack[q]; an inv_ack on a port not being invalidated SHALL be ignored.
REQ-025 L2_REQ SHALL hold l2_* stable until l2_valid && l2_ready.
REQ-026 After an L2 read is accepted, L2_WAIT SHALL wait for l2_rsp_valid; an accepted L2 write SHALL go straight to RESP.
REQ-027 RESP SHALL pulse rsp_valid[p] for exactly 1 cycle, update the directory entry in the same cycle, and return to IDLE.
REQ-028 Minimum latency SHALL be 5 cycles from accept to rsp_valid for an uncached read with zero-wait L2: accept, LOOKUP, L2_REQ, L2_WAIT, RESP.
REQ-029 One transaction SHALL be in flight at a time; req_ready SHALL be 0 outside IDLE.
REQ-030 Reserved op SHALL be acked with rsp_valid only, with no directory change.

Reset
REQ-031 While rst is high, all outputs SHALL be 0, all entries UNCACHED with sharers 0, FSM IDLE and round-robin pointer 0.
REQ-032 Reset mid-transaction SHALL abort it with no rsp_valid issued and no directory update.

Structure
REQ-033 Package dir_pkg SHALL hold the op encodings, directory state encodings, FSM state enum and the entry struct typedef.
REQ-034 Sub-module dir_rr_arb SHALL implement the 2-port round-robin grant.

Verification
REQ-035 The bench SHALL cover: reset, then P0 RD_MISS 0x10, L2 returns 0xAB -> rsp_valid[0] 5 cycles after accept with data 0xAB, entry SHARED {P0}.
REQ-036 The bench SHALL cover: P0 WR_MISS 0x10 while SHARED {P0,P1} -> inv_valid[1] with inv_addr 0x10; after ack, L2 read; entry MODIFIED {P0}.
REQ-037 The bench SHALL cover: P1 RD_MISS 0x10 while MODIFIED {P0}, inv_data 0x5C -> L2 write 0x10/0x5C, rsp_data 0x5C, entry SHARED {P1}.
REQ-038 The bench SHALL cover: both ports valid in the same cycle, twice -> grants P0, then P1.
REQ-039 The bench SHALL cover: P0 WRITEBACK 0x22 data 0x7E while MODIFIED {P0} -> L2 write 0x22/0x7E, entry UNCACHED.
REQ-040 The bench SHALL cover: rst asserted during INVAL -> next cycle all outputs 0, entry 0x10 UNCACHED.

Source files
------------

// File: rtl/dir_pkg.sv
// Shared encodings for the two-port coherence directory controller.
package dir_pkg;

   typedef enum logic [1:0] {
      RD_MISS   = 2'd0,
      WR_MISS   = 2'd1,
      WRITEBACK = 2'd2,
      OP_RSVD   = 2'd3
   } dirOpT;

   typedef enum logic [1:0] {
      UNCACHED = 2'd0,
      SHARED   = 2'd1,
      MODIFIED = 2'd2
   } dirStateT;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, INVAL, L2_REQ, L2_WAIT, RESP
   } fsmStateT;

   typedef struct packed {
      dirStateT   dirState;
      logic [1:0] sharers;
   } dirEntryT;

   localparam dirEntryT ENTRY_RESET = '{dirState: UNCACHED, sharers: 2'b00};

   function automatic logic [1:0] portMask(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dir_rr_arb.sv
// Two-port round-robin arbiter; after a grant, priority passes to the other port.
module dir_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst)          ptr <= 1'b0;
      else if (advance) ptr <= grant[0];
   end

endmodule

// File: rtl/directory_ctrl.sv
// Directory controller for two L1 ports in front of cacheL2; one transaction at a time.
//   state   | meaning
//   IDLE    | arbitrate and latch a request
//   LOOKUP  | read entry, choose invalidate / L2 / respond path
//   INVAL   | hold invalidate to the other port until it acks
//   L2_REQ  | hold L2 read or write until accepted
//   L2_WAIT | wait for L2 read data
//   RESP    | pulse response, commit directory entry
module directory_ctrl
   import dir_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [3:0]          req_op,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_data,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [1:0]          inv_valid,
   output logic [ADDR_W-1:0]   inv_addr,
   input  logic [1:0]          inv_ack,
   input  logic [2*DATA_W-1:0] inv_data,
   output logic                l2_valid,
   output logic                l2_write,
   output logic [ADDR_W-1:0]   l2_addr,
   output logic [DATA_W-1:0]   l2_data,
   input  logic                l2_ready,
   input  logic                l2_rsp_valid,
   input  logic [DATA_W-1:0]   l2_rsp_data
);

   localparam int DEPTH = 2**ADDR_W;

   fsmStateT          state, stateNext;
   dirEntryT          dirMem [DEPTH];
   dirEntryT          cur, newEntry;
   dirOpT             op;
   logic              port, other, winIdx, accept;
   logic [1:0]        grant;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wbData, xferData;
   logic              l2Write, wasMod, doUpdate;
   logic              ownerIsOther, wbHit;

   assign accept       = (state == IDLE) && (|req_valid) && !rst;
   assign winIdx       = grant[1];
   assign other        = ~port;
   assign cur          = dirMem[addr];
   assign ownerIsOther = (cur.dirState == MODIFIED) && cur.sharers[other];
   assign wbHit        = (cur.dirState == MODIFIED) && cur.sharers[port];

   dir_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      stateNext = state;
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      inv_valid = '0;
      inv_addr  = '0;
      l2_valid  = 1'b0;
      l2_write  = 1'b0;
      l2_addr   = '0;
      l2_data   = '0;
      case (state)
         IDLE: if (accept) begin
            req_ready = grant;
            stateNext = LOOKUP;
         end
         LOOKUP: case (op)
            RD_MISS:   stateNext = ownerIsOther      ? INVAL  : L2_REQ;
            WR_MISS:   stateNext = cur.sharers[other] ? INVAL  : L2_REQ;
            WRITEBACK: stateNext = wbHit             ? L2_REQ : RESP;
            default:   stateNext = RESP;
         endcase
         INVAL: begin
            inv_valid[other] = 1'b1;
            inv_addr         = addr;
            // A dirty owner on a write miss hands its data straight to the requester
            if (inv_ack[other]) stateNext = (op == WR_MISS && wasMod) ? RESP : L2_REQ;
         end
         L2_REQ: begin
            l2_valid = 1'b1;
            l2_write = l2Write;
            l2_addr  = addr;
            l2_data  = l2Write ? xferData : '0;
            if (l2_ready) stateNext = l2Write ? RESP : L2_WAIT;
         end
         L2_WAIT: if (l2_rsp_valid) stateNext = RESP;
         RESP: begin
            rsp_valid[port] = 1'b1;
            rsp_data        = xferData;
            stateNext       = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (rst) begin
         req_ready = '0;
         rsp_valid = '0;
         rsp_data  = '0;
         inv_valid = '0;
         inv_addr  = '0;
         l2_valid  = 1'b0;
         l2_write  = 1'b0;
         l2_addr   = '0;
         l2_data   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         port     <= 1'b0;
         op       <= RD_MISS;
         addr     <= '0;
         wbData   <= '0;
         xferData <= '0;
         l2Write  <= 1'b0;
         wasMod   <= 1'b0;
         doUpdate <= 1'b0;
         newEntry <= ENTRY_RESET;
         for (int i = 0; i < DEPTH; i++) dirMem[i] <= ENTRY_RESET;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: if (accept) begin
               port   <= winIdx;
               op     <= dirOpT'(winIdx ? req_op[3:2] : req_op[1:0]);
               addr   <= winIdx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               wbData <= winIdx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
            end
            LOOKUP: begin
               wasMod   <= (cur.dirState == MODIFIED);
               xferData <= wbData;
               l2Write  <= 1'b0;
               doUpdate <= 1'b1;
               newEntry <= cur;
               case (op)
                  RD_MISS: begin
                     l2Write  <= ownerIsOther;
                     newEntry <= '{dirState: SHARED,
                                   sharers: ownerIsOther ? portMask(port)
                                                         : (cur.sharers | portMask(port))};
                  end
                  WR_MISS:   newEntry <= '{dirState: MODIFIED, sharers: portMask(port)};
                  WRITEBACK: begin
                     l2Write  <= wbHit;
                     doUpdate <= wbHit;
                     newEntry <= ENTRY_RESET;
                  end
                  default:   doUpdate <= 1'b0;
               endcase
            end
            INVAL: if (inv_ack[other])
               xferData <= other ? inv_data[2*DATA_W-1:DATA_W] : inv_data[DATA_W-1:0];
            L2_WAIT: if (l2_rsp_valid) xferData <= l2_rsp_data;
            RESP: if (doUpdate) dirMem[addr] <= newEntry;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_directory_ctrl.sv
// Directed bench for directory_ctrl: coherence scenarios, arbitration and reset abort.
module tb_directory_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [3:0]  req_op = '0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_data = '0;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  inv_valid;
   logic [7:0]  inv_addr;
   logic [1:0]  inv_ack = '0;
   logic [15:0] inv_data = '0;
   logic        l2_valid, l2_write;
   logic [7:0]  l2_addr, l2_data;
   logic        l2_ready = 1'b0;
   logic        l2_rsp_valid = 1'b0;
   logic [7:0]  l2_rsp_data = '0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   directory_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .inv_valid    (inv_valid),
      .inv_addr     (inv_addr),
      .inv_ack      (inv_ack),
      .inv_data     (inv_data),
      .l2_valid     (l2_valid),
      .l2_write     (l2_write),
      .l2_addr      (l2_addr),
      .l2_data      (l2_data),
      .l2_ready     (l2_ready),
      .l2_rsp_valid (l2_rsp_valid),
      .l2_rsp_data  (l2_rsp_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkEntry(input string tag, input logic [7:0] a, input logic [3:0] exp);
      chk(tag, 64'(dut.dirMem[a]), 64'(exp));
   endtask

   task automatic chkAllZero(input string tag);
      chk(tag, {24'd0, req_ready, rsp_valid, inv_valid, l2_valid, l2_write,
                l2_addr, l2_data, rsp_data, inv_addr}, 64'd0);
   endtask

   task automatic nextCyc();
      @(posedge clk);
      #1;
   endtask

   // Drives one request, checks its grant, returns at the negedge of the LOOKUP cycle
   task automatic request(input int p, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] d);
      nextCyc();
      req_valid           = '0;
      req_valid[p]        = 1'b1;
      req_op[2*p +: 2]    = o;
      req_addr[8*p +: 8]  = a;
      req_data[8*p +: 8]  = d;
      @(negedge clk);
      chk("grant", 64'(req_ready), (p == 1) ? 64'd2 : 64'd1);
      nextCyc();
      req_valid = '0;
      @(negedge clk);
   endtask

   // Zero-wait L2 read; returns at the negedge of the RESP cycle
   task automatic l2Read(input logic [7:0] a, input logic [7:0] rdata);
      nextCyc();
      inv_ack  = '0;
      l2_ready = 1'b1;
      @(negedge clk);
      chk("l2rd_req", {47'd0, l2_valid, l2_write, 7'd0, l2_addr}, {47'd0, 1'b1, 1'b0, 7'd0, a});
      nextCyc();
      l2_ready     = 1'b0;
      l2_rsp_valid = 1'b1;
      l2_rsp_data  = rdata;
      @(negedge clk);
      chk("early_rsp", 64'(rsp_valid), 64'd0);
      nextCyc();
      l2_rsp_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset, with both ports requesting to show req_ready stays low
      req_valid = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkAllZero("reset_outputs");
      chkEntry("reset_entry", 8'h10, 4'h0);
      nextCyc();
      rst       = 1'b0;
      req_valid = '0;

      // P0 RD_MISS 0x10, uncached: rsp four edges after the accept cycle
      request(0, 2'd0, 8'h10, 8'h00);
      chk("lookup_busy", 64'(req_ready), 64'd0);
      l2Read(8'h10, 8'hAB);
      chk("rd1_rsp", {48'd0, 6'd0, rsp_valid, rsp_data}, {48'd0, 6'd0, 2'b01, 8'hAB});
      nextCyc();
      @(negedge clk);
      chkEntry("rd1_entry", 8'h10, 4'b0101);

      // P1 RD_MISS 0x10, shared: joins sharers
      request(1, 2'd0, 8'h10, 8'h00);
      l2Read(8'h10, 8'hAB);
      chk("rd2_rsp", {48'd0, 6'd0, rsp_valid, rsp_data}, {48'd0, 6'd0, 2'b10, 8'hAB});
      nextCyc();
      @(negedge clk);
      chkEntry("rd2_entry", 8'h10, 4'b0111);

      // P0 WR_MISS 0x10 while SHARED {P0,P1}: invalidate P1, then L2 read
      request(0, 2'd1, 8'h10, 8'h00);
      nextCyc();
      @(negedge clk);
      chk("wr_inv", {46'd0, inv_valid, l2_valid, 6'd0, inv_addr}, {46'd0, 2'b10, 1'b0, 6'd0, 8'h10});
      nextCyc();
      inv_ack = 2'b01;
      @(negedge clk);
      nextCyc();
      inv_ack = 2'b00;
      @(negedge clk);
      chk("inv_wrong_ack_ignored", 64'(inv_valid), 64'd2);
      nextCyc();
      inv_ack  = 2'b10;
      inv_data = 16'h3300;
      @(negedge clk);
      l2Read(8'h10, 8'hC4);
      chk("wr_rsp", {48'd0, 6'd0, rsp_valid, rsp_data}, {48'd0, 6'd0, 2'b01, 8'hC4});
      nextCyc();
      @(negedge clk);
      chkEntry("wr_entry", 8'h10, 4'b1001);

      // P1 RD_MISS 0x10 while MODIFIED {P0}: recall 0x5C, write it to L2
      request(1, 2'd0, 8'h10, 8'h00);
      nextCyc();
      @(negedge clk);
      chk("rdm_inv", 64'(inv_valid), 64'd1);
      nextCyc();
      inv_ack  = 2'b01;
      inv_data = 16'h005C;
      @(negedge clk);
      nextCyc();
      inv_ack = 2'b00;
      @(negedge clk);
      chk("rdm_l2wr", {46'd0, l2_valid, l2_write, l2_addr, l2_data}, {46'd0, 1'b1, 1'b1, 8'h10, 8'h5C});
      nextCyc();
      l2_ready = 1'b1;
      @(negedge clk);
      chk("rdm_l2_hold", {46'd0, l2_valid, l2_write, l2_addr, l2_data}, {46'd0, 1'b1, 1'b1, 8'h10, 8'h5C});
      nextCyc();
      l2_ready = 1'b0;
      @(negedge clk);
      chk("rdm_rsp", {48'd0, 6'd0, rsp_valid, rsp_data}, {48'd0, 6'd0, 2'b10, 8'h5C});
      nextCyc();
      @(negedge clk);
      chkEntry("rdm_entry", 8'h10, 4'b0110);

      // Both ports at once, twice, reserved op: P0 then P1, no directory change
      nextCyc();
      req_valid = 2'b11;
      req_op    = 4'hF;
      req_addr  = 16'h1010;
      @(negedge clk);
      chk("rr_first", 64'(req_ready), 64'd1);
      nextCyc();
      req_valid = '0;
      @(negedge clk);
      nextCyc();
      @(negedge clk);
      chk("rsvd_rsp0", 64'(rsp_valid), 64'd1);
      nextCyc();
      req_valid = 2'b11;
      @(negedge clk);
      chk("rr_second", 64'(req_ready), 64'd2);
      nextCyc();
      req_valid = '0;
      @(negedge clk);
      nextCyc();
      @(negedge clk);
      chk("rsvd_rsp1", {61'd0, l2_valid, rsp_valid}, {61'd0, 1'b0, 2'b10});
      nextCyc();
      @(negedge clk);
      chkEntry("rsvd_entry", 8'h10, 4'b0110);

      // P0 WR_MISS 0x22 uncached, then WRITEBACK 0x7E
      request(0, 2'd1, 8'h22, 8'h00);
      l2Read(8'h22, 8'h11);
      chk("wr22_rsp", {48'd0, 6'd0, rsp_valid, rsp_data}, {48'd0, 6'd0, 2'b01, 8'h11});
      nextCyc();
      @(negedge clk);
      chkEntry("wr22_entry", 8'h22, 4'b1001);
      request(0, 2'd2, 8'h22, 8'h7E);
      nextCyc();
      l2_ready = 1'b1;
      @(negedge clk);
      chk("wb_l2wr", {46'd0, l2_valid, l2_write, l2_addr, l2_data}, {46'd0, 1'b1, 1'b1, 8'h22, 8'h7E});
      nextCyc();
      l2_ready = 1'b0;
      @(negedge clk);
      chk("wb_rsp", 64'(rsp_valid), 64'd1);
      nextCyc();
      @(negedge clk);
      chkEntry("wb_entry", 8'h22, 4'b0000);

      // WRITEBACK from a non-owner: response only, no L2 access
      request(1, 2'd2, 8'h22, 8'h55);
      nextCyc();
      @(negedge clk);
      chk("wbmiss_rsp", {61'd0, l2_valid, rsp_valid}, {61'd0, 1'b0, 2'b10});
      nextCyc();
      @(negedge clk);
      chkEntry("wbmiss_entry", 8'h22, 4'b0000);

      // Reset during INVAL aborts the transaction
      request(0, 2'd1, 8'h10, 8'h00);
      nextCyc();
      @(negedge clk);
      chk("abort_inv", 64'(inv_valid), 64'd2);
      nextCyc();
      rst = 1'b1;
      @(negedge clk);
      chkAllZero("abort_rst_high");
      nextCyc();
      @(negedge clk);
      chkAllZero("abort_after");
      chkEntry("abort_entry", 8'h10, 4'b0000);
      nextCyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkAllZero("abort_quiet");
         nextCyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
